// File: rtl/seg_msg_sequencer.sv
// Sequences characters of a 7-segment message: debounced button or prescaled tick
// advances the ROM index, with a blank gap inserted between successive characters.
module seg_msg_sequencer #(
    parameter int IDX_W        = 4,
    parameter int DEB_CYCLES   = 65536,
    parameter int TICK_DIV     = 1000000,
    parameter int BLANK_CYCLES = 2000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_raw,
    input  logic             mode_auto,
    input  logic [2:0]       speed,
    input  logic [IDX_W-1:0] msg_last,
    input  logic [7:0]       glyph,
    output logic [7:0]       seg_out,
    output logic [IDX_W-1:0] char_idx,
    output logic             step_evt,
    output logic [1:0]       phase
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(TICK_DIV * 8 + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d, deb_prev_q, btn_req_q;
    logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
    logic [PW-1:0]    presc_q, presc_d, presc_lim;
    logic [BW-1:0]    blank_q, blank_d;
    logic [7:0]       seg_q, seg_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_next;
    logic             tick, req, accept;

    // The debounced level flips on the DEB_CYCLES-th consecutive disagreeing sample.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign presc_lim = PW'(TICK_DIV * (int'(speed) + 1) - 1);
    assign tick      = mode_auto && (state_q != BLANK) && (presc_q == presc_lim);
    assign req       = mode_auto ? tick : btn_req_q;
    assign accept    = req && (state_q != BLANK);
    assign idx_next  = (idx_q >= msg_last) ? '0 : idx_q + 1'b1;

    // Prescaler freezes during the gap; a lowered limit just lets it wrap at full width.
    always_comb begin
        if (!mode_auto || accept) begin
            presc_d = '0;
        end else if (state_q == BLANK) begin
            presc_d = presc_q;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        idx_d   = idx_q;
        blank_d = blank_q;
        case (state_q)
            IDLE: begin
                seg_d = '0;
                if (accept) begin
                    state_d = SHOW;
                    seg_d   = glyph;
                end
            end
            SHOW: begin
                if (accept) begin
                    state_d = BLANK;
                    seg_d   = '0;
                    blank_d = '0;
                    idx_d   = idx_next;
                end
            end
            BLANK: begin
                if (blank_q == BW'(BLANK_CYCLES - 1)) begin
                    state_d = SHOW;
                    seg_d   = glyph;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                seg_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            btn_req_q  <= 1'b0;
            deb_cnt_q  <= '0;
            presc_q    <= '0;
            blank_q    <= '0;
            seg_q      <= '0;
            idx_q      <= '0;
            state_q    <= IDLE;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            btn_req_q  <= deb_q & ~deb_prev_q;
            deb_cnt_q  <= deb_cnt_d;
            presc_q    <= presc_d;
            blank_q    <= blank_d;
            seg_q      <= seg_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
        end
    end

    assign seg_out  = seg_q;
    assign char_idx = idx_q;
    assign step_evt = accept;
    assign phase    = state_q;

endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Directed bench for seg_msg_sequencer with small parameters and a one-cycle glyph ROM model.
module tb_seg_msg_sequencer;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       btn_raw   = 1'b0;
    logic       mode_auto = 1'b0;
    logic [2:0] speed     = 3'd0;
    logic [3:0] msg_last  = 4'd15;
    logic [7:0] glyph     = 8'h00;
    logic [7:0] seg_out;
    logic [3:0] char_idx;
    logic       step_evt;
    logic [1:0] phase;

    int checks    = 0;
    int errors    = 0;
    int stepCount = 0;

    seg_msg_sequencer #(
        .IDX_W(4), .DEB_CYCLES(4), .TICK_DIV(8), .BLANK_CYCLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .mode_auto(mode_auto),
        .speed(speed), .msg_last(msg_last), .glyph(glyph), .seg_out(seg_out),
        .char_idx(char_idx), .step_evt(step_evt), .phase(phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) glyph <= 8'hA0 + {4'h0, char_idx};

    always @(negedge clk) if (step_evt === 1'b1) stepCount++;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cyc(2);
        checks++;
        if ({phase, char_idx, seg_out, step_evt} !== {2'd0, 4'd0, 8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state got ph=%0d idx=%0d seg=%h stp=%b want 0/0/00/0", phase, char_idx, seg_out, step_evt);
        end
        rst_n = 1'b1;
        cyc(3);
        checks++;
        if ({phase, char_idx, seg_out} !== {2'd0, 4'd0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reset_release got ph=%0d idx=%0d seg=%h want 0/0/00", phase, char_idx, seg_out);
        end
    endtask

    task automatic test_manual_clean();
        int firstK;
        int nSteps;
        for (int p = 0; p < 2; p++) begin
            firstK  = -1;
            nSteps  = 0;
            btn_raw = 1'b1;
            for (int k = 1; k <= 20; k++) begin
                cyc(1);
                if (step_evt === 1'b1) begin
                    nSteps++;
                    if (firstK < 0) firstK = k;
                end
                if (p == 0 && k == 7) begin
                    checks++;
                    if ({phase, seg_out} !== {2'd0, 8'h00}) begin
                        errors++;
                        $display("[TB] FAIL press1_pre got ph=%0d seg=%h want 0/00", phase, seg_out);
                    end
                end
                if (p == 0 && k == 8) begin
                    checks++;
                    if ({phase, char_idx, seg_out} !== {2'd1, 4'd0, 8'hA0}) begin
                        errors++;
                        $display("[TB] FAIL press1_show got ph=%0d idx=%0d seg=%h want 1/0/a0", phase, char_idx, seg_out);
                    end
                end
                if (p == 1 && k >= 8 && k <= 10) begin
                    checks++;
                    if ({phase, char_idx, seg_out} !== {2'd2, 4'd1, 8'h00}) begin
                        errors++;
                        $display("[TB] FAIL press2_blank k=%0d got ph=%0d idx=%0d seg=%h want 2/1/00", k, phase, char_idx, seg_out);
                    end
                end
                if (p == 1 && k == 11) begin
                    checks++;
                    if ({phase, char_idx, seg_out} !== {2'd1, 4'd1, 8'hA1}) begin
                        errors++;
                        $display("[TB] FAIL press2_show got ph=%0d idx=%0d seg=%h want 1/1/a1", phase, char_idx, seg_out);
                    end
                end
                if (k == 10) btn_raw = 1'b0;
            end
            checks++;
            if (firstK != 7 || nSteps != 1) begin
                errors++;
                $display("[TB] FAIL press%0d_step got first=%0d count=%0d want 7/1", p + 1, firstK, nSteps);
            end
        end
    endtask

    task automatic test_bouncy();
        logic [8:0] pat1 = 9'b101101110;
        logic [8:0] pat2 = 9'b010010001;
        int s0;
        s0 = stepCount;
        for (int i = 8; i >= 0; i--) begin
            btn_raw = pat1[i];
            cyc(1);
        end
        btn_raw = 1'b1;
        cyc(16);
        checks++;
        if (stepCount - s0 != 1 || {phase, char_idx, seg_out} !== {2'd1, 4'd2, 8'hA2}) begin
            errors++;
            $display("[TB] FAIL bouncy_press got steps=%0d ph=%0d idx=%0d seg=%h want 1 1/2/a2", stepCount - s0, phase, char_idx, seg_out);
        end
        s0 = stepCount;
        for (int i = 8; i >= 0; i--) begin
            btn_raw = pat2[i];
            cyc(1);
        end
        btn_raw = 1'b0;
        cyc(16);
        checks++;
        if (stepCount - s0 != 0 || {phase, char_idx, seg_out} !== {2'd1, 4'd2, 8'hA2}) begin
            errors++;
            $display("[TB] FAIL bouncy_release got steps=%0d ph=%0d idx=%0d seg=%h want 0 1/2/a2", stepCount - s0, phase, char_idx, seg_out);
        end
    endtask

    task automatic test_auto();
        logic        expStep;
        logic [13:0] expVec;
        mode_auto = 1'b1;
        speed     = 3'd1;
        msg_last  = 4'd2;
        doReset();
        for (int k = 1; k <= 75; k++) begin
            cyc(1);
            expStep = (k == 15) || (k == 31) || (k == 50) || (k == 69);
            checks++;
            if (step_evt !== expStep) begin
                errors++;
                $display("[TB] FAIL auto_step k=%0d got %b want %b", k, step_evt, expStep);
            end
            expVec = 14'h0;
            case (k)
                16: expVec = {2'd1, 4'd0, 8'hA0};
                32: expVec = {2'd2, 4'd1, 8'h00};
                35: expVec = {2'd1, 4'd1, 8'hA1};
                51: expVec = {2'd2, 4'd2, 8'h00};
                54: expVec = {2'd1, 4'd2, 8'hA2};
                70: expVec = {2'd2, 4'd0, 8'h00};
                73: expVec = {2'd1, 4'd0, 8'hA0};
                default: ;
            endcase
            if (expVec != 14'h0) begin
                checks++;
                if ({phase, char_idx, seg_out} !== expVec) begin
                    errors++;
                    $display("[TB] FAIL auto_seq k=%0d got ph=%0d idx=%0d seg=%h want %h", k, phase, char_idx, seg_out, expVec);
                end
            end
        end
    endtask

    task automatic test_auto_ignores_button();
        int s0;
        mode_auto = 1'b1;
        speed     = 3'd7;
        msg_last  = 4'd15;
        doReset();
        s0      = stepCount;
        btn_raw = 1'b1;
        cyc(10);
        btn_raw = 1'b0;
        cyc(20);
        checks++;
        if (stepCount - s0 != 0 || phase !== 2'd0) begin
            errors++;
            $display("[TB] FAIL auto_btn_ignored got steps=%0d ph=%0d want 0/0", stepCount - s0, phase);
        end
    endtask

    task automatic test_blank_drop();
        int s0;
        mode_auto = 1'b1;
        speed     = 3'd0;
        msg_last  = 4'd15;
        doReset();
        s0 = stepCount;
        for (int k = 1; k <= 40; k++) begin
            cyc(1);
            if (k == 15) begin
                checks++;
                if (step_evt !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL drop_tick got %b want 1", step_evt);
                end
            end
            if (k == 16) begin
                checks++;
                if ({phase, char_idx} !== {2'd2, 4'd1}) begin
                    errors++;
                    $display("[TB] FAIL drop_blank got ph=%0d idx=%0d want 2/1", phase, char_idx);
                end
                mode_auto = 1'b0;
                s0        = stepCount;
            end
            if (k == 9) btn_raw = 1'b1;
        end
        checks++;
        if (stepCount - s0 != 0 || {phase, char_idx, seg_out} !== {2'd1, 4'd1, 8'hA1}) begin
            errors++;
            $display("[TB] FAIL drop_no_advance got steps=%0d ph=%0d idx=%0d seg=%h want 0 1/1/a1", stepCount - s0, phase, char_idx, seg_out);
        end
        btn_raw = 1'b0;
        cyc(12);
    endtask

    task automatic test_msg_last_lower();
        bit found;
        mode_auto = 1'b1;
        speed     = 3'd0;
        msg_last  = 4'd15;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc(1);
            if (phase == 2'd1 && char_idx == 4'd9) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL reach_idx9 timeout got ph=%0d idx=%0d want 1/9", phase, char_idx);
        end
        mode_auto = 1'b0;
        msg_last  = 4'd3;
        checks++;
        if (seg_out !== 8'hA9) begin
            errors++;
            $display("[TB] FAIL idx9_glyph got %h want a9", seg_out);
        end
        for (int p = 0; p < 2; p++) begin
            btn_raw = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                cyc(1);
                if (k == 7) begin
                    checks++;
                    if (step_evt !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL wrap%0d_step got %b want 1", p, step_evt);
                    end
                end
                if (k == 8) begin
                    checks++;
                    if ({phase, char_idx, seg_out} !== {2'd2, 4'd0, 8'h00}) begin
                        errors++;
                        $display("[TB] FAIL wrap%0d_blank got ph=%0d idx=%0d seg=%h want 2/0/00", p, phase, char_idx, seg_out);
                    end
                end
                if (k == 11) begin
                    checks++;
                    if ({phase, char_idx, seg_out} !== {2'd1, 4'd0, 8'hA0}) begin
                        errors++;
                        $display("[TB] FAIL wrap%0d_show got ph=%0d idx=%0d seg=%h want 1/0/a0", p, phase, char_idx, seg_out);
                    end
                end
                if (k == 10) btn_raw = 1'b0;
            end
            cyc(10);
            msg_last = 4'd0;
        end
    endtask

    task automatic test_reset_mid_blank();
        bit found;
        int s0;
        mode_auto = 1'b1;
        speed     = 3'd0;
        msg_last  = 4'd15;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc(1);
            if (phase == 2'd2 && char_idx == 4'd5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL reach_blank5 timeout got ph=%0d idx=%0d want 2/5", phase, char_idx);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({phase, char_idx, seg_out, step_evt} !== {2'd0, 4'd0, 8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_reset got ph=%0d idx=%0d seg=%h stp=%b want 0/0/00/0", phase, char_idx, seg_out, step_evt);
        end
        mode_auto = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        s0    = stepCount;
        cyc(10);
        checks++;
        if (stepCount - s0 != 0 || {phase, char_idx, seg_out} !== {2'd0, 4'd0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL post_reset_idle got steps=%0d ph=%0d idx=%0d seg=%h want 0 0/0/00", stepCount - s0, phase, char_idx, seg_out);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] start");
        test_reset();
        test_manual_clean();
        test_bouncy();
        test_auto();
        test_auto_ignores_button();
        test_blank_drop();
        test_msg_last_lower();
        test_reset_mid_blank();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
